muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, beside the ALU. It takes the M-extension operation (func3, with opcode 0110011 and func7 0000001 already decoded upstream) and two 32-bit operands. It runs a fixed-latency shift-add multiply or restoring divide, then returns the 32-bit result with a one-cycle done pulse. The pipeline stalls on busy.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- flush  in  1  abort any operation in flight.
- func3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value (multiplicand / dividend).
- op_b  in  XLEN  rs2 value (multiplier / divisor).
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse, result valid.
- result  out  XLEN  registered result; holds until the next done.

## Operation
- States:
  - IDLE to RUN on start; func3 and the operand magnitudes are latched, the sign-fix flags are latched, and cnt = 0.
  - RUN performs one iteration per cycle; at cnt = 31 it goes to FIN.
  - FIN applies sign correction and writes result, then goes to DONE.
  - DONE asserts done and returns to IDLE.
- Signedness:
  - MULH and DIV/REM treat both operands as signed.
  - MULHSU treats op_a as signed and op_b as unsigned.
  - MULHU, DIVU and REMU treat both as unsigned.
- Multiply:
  - 64-bit accumulator with radix-2 shift-add on the unsigned magnitudes.
  - If the operand signs differ, FIN two's-complement negates all 64 bits.
  - MUL returns bits [31:0]; the MULH variants return bits [63:32].
- Divide: 32-step restoring divide on the magnitudes.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero (op_b = 0): quotient = 0xFFFFFFFF, remainder = op_a unmodified. This takes the full latency; there is no early exit.
- Signed overflow (DIV/REM with op_a = 0x80000000, op_b = 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- start while busy is ignored; the new request is not queued.
- flush returns to IDLE on the next edge from any state. No done is produced and result is unchanged. flush has priority over start in IDLE.

## Timing
- Reset values: state IDLE, busy 0, done 0, result 0, cnt 0, internal accumulators 0.
- Let E0 be the edge that samples start:
  - RUN iterations occur at E1..E32.
  - FIN occurs at E33 and writes result.
  - done is high in the cycle between E33 and E34. Latency is 33 cycles for every op, including the special cases.
  - busy is high from after E0 until E34.
- result is already stable in the cycle done is high. The next start can be sampled at E34 or later, so back-to-back issue is every 34 cycles.
- An asynchronous reset mid-operation forces all reset values immediately. No partial result or done is produced.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - The four MUL ops skip RUN. IDLE goes to FIN at E0, where a single-cycle 33x33 signed multiply computes the product.
  - result is written at E1 and done is high between E1 and E2.
  - Divide ops are unchanged at 33 cycles.
- MULDIV_FAST_MUL_EN undefined: all ops are iterative with a latency of 33.

## Structure
- Package muldiv_pkg holds:
  - the func3 enum (MD_MUL..MD_REMU);
  - the state enum (IDLE, RUN, FIN, DONE);
  - the constants DIV0_Q = 32'hFFFFFFFF and ITER_LAST = 5'd31.
- Sub-module muldiv_operand_prep (combinational) produces the operand magnitudes and sign flags from func3, op_a and op_b. Everything else stays in muldiv_unit.

## Test plan
- MUL 0x00000007 × 0xFFFFFFFD (-3) → result 0xFFFFFFEB, done exactly 33 cycles after start, busy high for 34 cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7 / 2 → 0xFFFFFFFD; REM -7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIV 5 / 0 → 0xFFFFFFFF and REMU 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM of the same → 0. All at the full latency.
- start re-asserted during RUN with different operands → ignored, first result delivered. flush at cycle 10 → IDLE next edge, no done, result unchanged.
- rst pulsed mid-RUN → busy, done and result at 0 immediately. A following DIVU 9 / 3 → 3 with normal latency. With MULDIV_FAST_MUL_EN, MUL 6 × 7 → 42 with done one cycle after the start edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } md_state_e;

    localparam logic [31:0] DIV0_Q    = 32'hFFFFFFFF;
    localparam logic [4:0]  ITER_LAST = 5'd31;

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand conditioning: per-op signedness, sign bits and magnitudes.
module muldiv_operand_prep
    import muldiv_pkg::*;
(
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] mag_a,
    output logic [XLEN-1:0] mag_b,
    output logic            a_neg,
    output logic            b_neg,
    output logic            b_zero
);

    logic a_signed_s;
    logic b_signed_s;

    // MUL takes the unsigned path: its low word is identical either way.
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (func3)
            MD_MULH, MD_DIV, MD_REM: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            MD_MULHSU: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
    end

    assign a_neg  = a_signed_s & op_a[XLEN-1];
    assign b_neg  = b_signed_s & op_b[XLEN-1];
    assign mag_a  = a_neg ? (32'd0 - op_a) : op_a;
    assign mag_b  = b_neg ? (32'd0 - op_b) : op_b;
    assign b_zero = (op_b == 32'd0);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply / restoring divide.
// Optional single-cycle multiply when MULDIV_FAST_MUL_EN is defined.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    md_state_e   state_r;
    md_op_e      func3_r;
    logic [4:0]  cnt_r;
    logic [63:0] acc_r;
    logic [31:0] opnd_r;
    logic        neg_r;
    logic        negr_r;
    logic        div0_r;

    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic        b_zero_s;

    logic [32:0] sum_s;
    logic [32:0] rem_sh_s;
    logic [33:0] diff_s;
    logic [63:0] acc_step_s;
    logic [63:0] prod_s;
    logic [31:0] fin_s;

    muldiv_operand_prep u_prep (
        .func3  (func3),
        .op_a   (op_a),
        .op_b   (op_b),
        .mag_a  (mag_a_s),
        .mag_b  (mag_b_s),
        .a_neg  (a_neg_s),
        .b_neg  (b_neg_s),
        .b_zero (b_zero_s)
    );

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fast_prod_s;
    // Sign-extended 64x64 product equals the 33x33 signed product modulo 2^64.
    assign fast_prod_s = $signed({{32{a_neg_s}}, op_a}) * $signed({{32{b_neg_s}}, op_b});
`endif

    // One iteration: acc holds {hi, multiplier} for multiply, {remainder, quotient} for divide.
    always_comb begin
        sum_s    = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
        rem_sh_s = {acc_r[63:32], acc_r[31]};
        diff_s   = {1'b0, rem_sh_s} - {2'b00, opnd_r};
        if (func3_r[2]) begin
            if (!diff_s[33]) begin
                acc_step_s = {diff_s[31:0], acc_r[30:0], 1'b1};
            end else begin
                acc_step_s = {rem_sh_s[31:0], acc_r[30:0], 1'b0};
            end
        end else begin
            acc_step_s = {sum_s, acc_r[31:1]};
        end
    end

    // Sign correction and result selection applied in FIN.
    always_comb begin
        prod_s = neg_r ? (64'd0 - acc_r) : acc_r;
        case (func3_r)
            MD_MUL:                       fin_s = prod_s[31:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fin_s = prod_s[63:32];
            MD_DIV, MD_DIVU: begin
                if (div0_r) begin
                    fin_s = DIV0_Q;
                end else begin
                    fin_s = neg_r ? (32'd0 - acc_r[31:0]) : acc_r[31:0];
                end
            end
            MD_REM, MD_REMU: fin_s = negr_r ? (32'd0 - acc_r[63:32]) : acc_r[63:32];
            default:         fin_s = 32'd0;
        endcase
    end

    // Control FSM with registered busy/done/result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            func3_r <= MD_MUL;
            cnt_r   <= 5'd0;
            acc_r   <= 64'd0;
            opnd_r  <= 32'd0;
            neg_r   <= 1'b0;
            negr_r  <= 1'b0;
            div0_r  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= 32'd0;
        end else if (flush) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        func3_r <= md_op_e'(func3);
                        cnt_r   <= 5'd0;
                        neg_r   <= a_neg_s ^ b_neg_s;
                        negr_r  <= a_neg_s;
                        div0_r  <= b_zero_s;
                        busy    <= 1'b1;
                        state_r <= RUN;
                        if (func3[2]) begin
                            opnd_r <= mag_b_s;
                            acc_r  <= {32'd0, mag_a_s};
                        end else begin
                            opnd_r <= mag_a_s;
                            acc_r  <= {32'd0, mag_b_s};
`ifdef MULDIV_FAST_MUL_EN
                            acc_r   <= fast_prod_s;
                            neg_r   <= 1'b0;
                            state_r <= FIN;
`endif
                        end
                    end
                end
                RUN: begin
                    acc_r <= acc_step_s;
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == ITER_LAST) begin
                        state_r <= FIN;
                    end
                end
                FIN: begin
                    result  <= fin_s;
                    done    <= 1'b1;
                    state_r <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors, monitor checks result and latency on done.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  func3 = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    typedef struct {
        string       nm;
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .func3  (func3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL spurious_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check32({e.nm, " result"}, result, e.res);
                check_int({e.nm, " latency"}, cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input bit push, input string nm);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        func3 = f;
        op_a  = a;
        op_b  = b;
        if (push) begin
            e.nm  = nm;
            e.res = exp;
            e.cyc = cyc + lat + 1;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        if (n >= 100) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL %s timeout: got busy after %0d cycles expected idle", nm, n);
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int lat;
        int n;
        lat = (FAST && !f[2]) ? 1 : 33;
        issue(f, a, b, exp, lat, 1'b1, nm);
        wait_idle(nm, n);
        check_int({nm, " busy_cycles"}, n, lat + 1);
        check_int({nm, " pending"}, sb_q.size(), 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check32("reset busy", {31'd0, busy}, 32'd0);
        check32("reset done", {31'd0, done}, 32'd0);
        check32("reset result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("mul_7x-3",      3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB);
        run_op("mulh_min",      3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
        run_op("mulhu_max",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("mulhsu_max",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("mul_6x7",       3'b000, 32'd6,        32'd7,        32'd42);
        run_op("div_-7_2",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
        run_op("rem_-7_2",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
        run_op("divu_100_7",    3'b101, 32'd100,      32'd7,        32'd14);
        run_op("remu_100_7",    3'b111, 32'd100,      32'd7,        32'd2);
        run_op("div_5_0",       3'b100, 32'd5,        32'd0,        32'hFFFFFFFF);
        run_op("div_-5_0",      3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF);
        run_op("rem_-5_0",      3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB);
        run_op("remu_5_0",      3'b111, 32'd5,        32'd0,        32'd5);
        run_op("div_ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_op("rem_ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);

        // start during RUN must be ignored
        issue(3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b1, "ignore_start");
        repeat (5) @(negedge clk);
        start = 1'b1;
        func3 = 3'b000;
        op_a  = 32'd3;
        op_b  = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ignore_start", n);
        check_int("ignore_start busy_cycles", n, 28);
        check_int("ignore_start pending", sb_q.size(), 0);
        repeat (40) @(negedge clk);

        // flush mid-run: idle after next edge, result held
        issue(3'b101, 32'd9, 32'd3, 32'd0, 33, 1'b0, "flush");
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check32("flush busy", {31'd0, busy}, 32'd0);
        check32("flush done", {31'd0, done}, 32'd0);
        check32("flush result", result, 32'd14);
        repeat (40) @(negedge clk);
        check32("flush result_held", result, 32'd14);

        // async reset mid-run clears outputs without a clock edge
        issue(3'b101, 32'd100, 32'd7, 32'd0, 33, 1'b0, "rst_mid");
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check32("rst_mid busy", {31'd0, busy}, 32'd0);
        check32("rst_mid done", {31'd0, done}, 32'd0);
        check32("rst_mid result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3);

        repeat (40) @(negedge clk);
        check_int("final pending", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
